serial_adder: RTL

- Parametrised multi-cycle adder/subtractor; successor to the combinational half-adder cells.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, rippling the carry through a register between cycles.
- Uses a start/busy/done handshake. Results are registered and held until the next operation.
- Used where area matters more than latency, and as the reference datapath for the team's adder verification benches.

---
 rtl/serial_adder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: DIGIT bits per clock, carry held in a register
// between digits, start/busy/done handshake with the result held until the next run.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] partial_q, partial_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT:0]   dig_res;
  logic [WIDTH-1:0] partial_shift;

  assign dig_res = {1'b0, opa_q[DIGIT-1:0]} + {1'b0, opb_q[DIGIT-1:0]}
                 + {{DIGIT{1'b0}}, carry_q};

  // Low digits are produced first, so each new digit enters at the top.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign partial_shift = dig_res[DIGIT-1:0];
    end else begin : g_multi
      assign partial_shift = {dig_res[DIGIT-1:0], partial_q[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    partial_d = partial_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        opa_d     = opa_q >> DIGIT;
        opb_d     = opb_q >> DIGIT;
        partial_d = partial_shift;
        carry_d   = dig_res[DIGIT];
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) begin
          sum_d   = partial_shift;
          cout_d  = dig_res[DIGIT];
          // Same-sign operands producing an opposite-sign result.
          ovf_d   = (opa_q[DIGIT-1] == opb_q[DIGIT-1]) &&
                    (dig_res[DIGIT-1] != opa_q[DIGIT-1]);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      opa_q     <= '0;
      opb_q     <= '0;
      partial_q <= '0;
      sum_q     <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      partial_q <= partial_d;
      sum_q     <= sum_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
